// File: rtl/pos_ring_remote_gateway.sv
// Ring/remote gateway node: extracts ring slots to remote destinations,
// injects buffered remote packets into free slots, renormalises GCIDs.
module pos_ring_remote_gateway #(
    parameter int OFFSET_W   = 32,
    parameter int GCID_W     = 4,
    parameter int LIFE_W     = 5,
    parameter int NUM_REMOTE = 2,
    parameter int X_DIM      = 3,
    parameter int Y_DIM      = 3,
    parameter int Z_DIM      = 3,
    parameter int INJ_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2:0]                     i_local_node_id,
    input  logic [OFFSET_W-1:0]            i_ring_pkt,
    input  logic [3*GCID_W-1:0]            i_ring_gcid,
    input  logic [2:0]                     i_ring_node_id,
    input  logic [LIFE_W-1:0]              i_ring_life,
    input  logic [NUM_REMOTE*LIFE_W-1:0]   i_ring_split,
    input  logic [NUM_REMOTE-1:0]          i_rem_bp,
    input  logic                           i_inj_valid,
    output logic                           o_inj_ready,
    input  logic [OFFSET_W-1:0]            i_inj_pkt,
    input  logic [3*GCID_W-1:0]            i_inj_gcid,
    input  logic [LIFE_W-1:0]              i_inj_life,
    output logic [OFFSET_W-1:0]            o_ring_pkt,
    output logic [3*GCID_W-1:0]            o_ring_gcid,
    output logic [2:0]                     o_ring_node_id,
    output logic [LIFE_W-1:0]              o_ring_life,
    output logic [NUM_REMOTE*LIFE_W-1:0]   o_ring_split,
    output logic [OFFSET_W-1:0]            o_rem_pkt,
    output logic [3*GCID_W-1:0]            o_rem_gcid,
    output logic [NUM_REMOTE-1:0]          o_rem_valid,
    output logic [NUM_REMOTE*LIFE_W-1:0]   o_rem_life,
    output logic [$clog2(INJ_DEPTH):0]     o_inj_count,
    output logic                           o_node_empty,
    output logic                           o_err_underflow
);

    localparam int PW  = $clog2(INJ_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW  = LIFE_W + $clog2(NUM_REMOTE);
    localparam int GW3 = 3 * GCID_W;
    localparam int SPW = NUM_REMOTE * LIFE_W;

    logic [OFFSET_W-1:0] ring_pkt_q, ring_pkt_d;
    logic [GW3-1:0]      ring_gcid_q, ring_gcid_d;
    logic [2:0]          ring_node_q, ring_node_d;
    logic [LIFE_W-1:0]   ring_life_q, ring_life_d;
    logic [SPW-1:0]      ring_split_q, ring_split_d;
    logic [OFFSET_W-1:0] rem_pkt_q, rem_pkt_d;
    logic [GW3-1:0]      rem_gcid_q, rem_gcid_d;
    logic [NUM_REMOTE-1:0] rem_valid_q, rem_valid_d;
    logic [SPW-1:0]      rem_life_q, rem_life_d;
    logic                err_q;
    logic [CW-1:0]       cnt_q;
    logic [PW-1:0]       rd_q, wr_q;

    logic [OFFSET_W-1:0] mem_pkt  [INJ_DEPTH];
    logic [GW3-1:0]      mem_gcid [INJ_DEPTH];
    logic [LIFE_W-1:0]   mem_life [INJ_DEPTH];

    logic [NUM_REMOTE-1:0] serve;
    logic [SW-1:0]       sum;
    logic [SPW-1:0]      split_kept;
    logic [SW-1:0]       life_ext;
    logic                under;
    logic [LIFE_W-1:0]   left;
    logic                keep;
    logic                fifo_empty, fifo_full, push, pop;
    logic [GW3-1:0]      head_gcid, inj_gcid, rem_gcid;
    logic [2:0]          inj_node;

    always_comb begin
        serve      = '0;
        sum        = '0;
        split_kept = i_ring_split;
        rem_life_d = '0;
        for (int d = 0; d < NUM_REMOTE; d++) begin
            serve[d] = (i_ring_split[d*LIFE_W +: LIFE_W] != '0)
                     && !i_rem_bp[d] && (i_ring_life != '0);
            if (serve[d]) begin
                sum = sum + SW'(i_ring_split[d*LIFE_W +: LIFE_W]);
                rem_life_d[d*LIFE_W +: LIFE_W] = i_ring_split[d*LIFE_W +: LIFE_W];
                split_kept[d*LIFE_W +: LIFE_W] = '0;
            end
        end
    end

    assign life_ext = SW'(i_ring_life);
    assign under    = sum > life_ext;
    assign left     = under ? '0 : LIFE_W'(life_ext - sum);
    assign keep     = left != '0;

    assign fifo_empty = cnt_q == '0;
    assign fifo_full  = cnt_q == CW'(INJ_DEPTH);
    assign push       = i_inj_valid && !fifo_full;
    assign pop        = !keep && !fifo_empty;
    assign head_gcid  = mem_gcid[rd_q];

    // Per axis: remote-frame offset for extraction, local-frame fold for injection.
    for (genvar a = 0; a < 3; a++) begin : g_axis
        localparam int DI = (a == 0) ? X_DIM : ((a == 1) ? Y_DIM : Z_DIM);
        localparam logic [GCID_W-1:0] DIM = GCID_W'(DI);
        logic [GCID_W-1:0] hc, rc;
        logic              l, r;
        assign l  = i_local_node_id[2-a];
        assign hc = head_gcid[a*GCID_W +: GCID_W];
        assign rc = i_ring_gcid[a*GCID_W +: GCID_W];
        assign r  = hc >= DIM;
        assign inj_gcid[a*GCID_W +: GCID_W] =
            (l && r) ? hc - DIM : ((!l || r) ? hc : hc + DIM);
        assign inj_node[2-a] = r;
        assign rem_gcid[a*GCID_W +: GCID_W] = rc + (l ? DIM : '0);
    end

    always_comb begin
        ring_pkt_d   = '0;
        ring_gcid_d  = '0;
        ring_node_d  = '0;
        ring_life_d  = '0;
        ring_split_d = '0;
        if (keep) begin
            ring_pkt_d   = i_ring_pkt;
            ring_gcid_d  = i_ring_gcid;
            ring_node_d  = i_ring_node_id;
            ring_life_d  = left;
            ring_split_d = split_kept;
        end else if (!fifo_empty) begin
            ring_pkt_d  = mem_pkt[rd_q];
            ring_gcid_d = inj_gcid;
            ring_node_d = inj_node;
            ring_life_d = mem_life[rd_q];
        end
    end

    assign rem_valid_d = serve;
    assign rem_pkt_d   = (|serve) ? i_ring_pkt : '0;
    assign rem_gcid_d  = (|serve) ? rem_gcid : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_pkt_q   <= '0;
            ring_gcid_q  <= '0;
            ring_node_q  <= '0;
            ring_life_q  <= '0;
            ring_split_q <= '0;
            rem_pkt_q    <= '0;
            rem_gcid_q   <= '0;
            rem_valid_q  <= '0;
            rem_life_q   <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
        end else begin
            ring_pkt_q   <= ring_pkt_d;
            ring_gcid_q  <= ring_gcid_d;
            ring_node_q  <= ring_node_d;
            ring_life_q  <= ring_life_d;
            ring_split_q <= ring_split_d;
            rem_pkt_q    <= rem_pkt_d;
            rem_gcid_q   <= rem_gcid_d;
            rem_valid_q  <= rem_valid_d;
            rem_life_q   <= rem_life_d;
            err_q        <= err_q | under;
            cnt_q        <= cnt_q + CW'(push) - CW'(pop);
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pkt[wr_q]  <= i_inj_pkt;
            mem_gcid[wr_q] <= i_inj_gcid;
            mem_life[wr_q] <= i_inj_life;
        end
    end

    assign o_ring_pkt      = ring_pkt_q;
    assign o_ring_gcid     = ring_gcid_q;
    assign o_ring_node_id  = ring_node_q;
    assign o_ring_life     = ring_life_q;
    assign o_ring_split    = ring_split_q;
    assign o_rem_pkt       = rem_pkt_q;
    assign o_rem_gcid      = rem_gcid_q;
    assign o_rem_valid     = rem_valid_q;
    assign o_rem_life      = rem_life_q;
    assign o_inj_count     = cnt_q;
    assign o_err_underflow = err_q;
    assign o_inj_ready     = !fifo_full;
    assign o_node_empty    = i_ring_life == '0;

endmodule

// File: tb/tb_pos_ring_remote_gateway.sv
// Scoreboard bench for pos_ring_remote_gateway: queue-based reference
// model predicts every output cycle, a monitor pops and compares.
module tb_pos_ring_remote_gateway;

    localparam int OW = 32;
    localparam int GW = 4;
    localparam int LW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      lid = 3'b000;
    logic [OW-1:0]   ring_pkt = '0;
    logic [3*GW-1:0] ring_gcid = '0;
    logic [2:0]      ring_node = '0;
    logic [LW-1:0]   ring_life = '0;
    logic [NR*LW-1:0] ring_split = '0;
    logic [NR-1:0]   rem_bp = '0;
    logic            inj_valid = 1'b0;
    logic [OW-1:0]   inj_pkt = '0;
    logic [3*GW-1:0] inj_gcid = '0;
    logic [LW-1:0]   inj_life = '0;

    logic            inj_ready;
    logic [OW-1:0]   o_ring_pkt;
    logic [3*GW-1:0] o_ring_gcid;
    logic [2:0]      o_ring_node;
    logic [LW-1:0]   o_ring_life;
    logic [NR*LW-1:0] o_ring_split;
    logic [OW-1:0]   o_rem_pkt;
    logic [3*GW-1:0] o_rem_gcid;
    logic [NR-1:0]   o_rem_valid;
    logic [NR*LW-1:0] o_rem_life;
    logic [CW-1:0]   o_cnt;
    logic            o_empty;
    logic            o_err;

    always #5 clk = ~clk;

    pos_ring_remote_gateway #(
        .OFFSET_W(OW), .GCID_W(GW), .LIFE_W(LW), .NUM_REMOTE(NR),
        .X_DIM(3), .Y_DIM(3), .Z_DIM(3), .INJ_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_local_node_id(lid),
        .i_ring_pkt(ring_pkt), .i_ring_gcid(ring_gcid),
        .i_ring_node_id(ring_node), .i_ring_life(ring_life),
        .i_ring_split(ring_split), .i_rem_bp(rem_bp),
        .i_inj_valid(inj_valid), .o_inj_ready(inj_ready),
        .i_inj_pkt(inj_pkt), .i_inj_gcid(inj_gcid), .i_inj_life(inj_life),
        .o_ring_pkt(o_ring_pkt), .o_ring_gcid(o_ring_gcid),
        .o_ring_node_id(o_ring_node), .o_ring_life(o_ring_life),
        .o_ring_split(o_ring_split), .o_rem_pkt(o_rem_pkt),
        .o_rem_gcid(o_rem_gcid), .o_rem_valid(o_rem_valid),
        .o_rem_life(o_rem_life), .o_inj_count(o_cnt),
        .o_node_empty(o_empty), .o_err_underflow(o_err)
    );

    typedef struct {
        logic [OW-1:0] pkt; logic [3*GW-1:0] gcid; logic [LW-1:0] life;
    } ent_t;
    typedef struct {
        logic [OW-1:0] rpkt; logic [3*GW-1:0] rgcid; logic [2:0] rnode;
        logic [LW-1:0] rlife; logic [NR*LW-1:0] rsplit;
        logic [OW-1:0] mpkt; logic [3*GW-1:0] mgcid;
        logic [NR-1:0] mvalid; logic [NR*LW-1:0] mlife;
        logic [CW-1:0] cnt; logic err;
    } exp_t;
    typedef struct { logic empty; logic ready; } cexp_t;

    ent_t  fifo[$];
    exp_t  qreg[$];
    cexp_t qcomb[$];
    bit    merr = 1'b0;
    int    checks = 0;
    int    passed = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    // Remote frame: node half on an axis shifts that coordinate by one node width.
    function automatic logic [3*GW-1:0] to_remote(logic [3*GW-1:0] g, logic [2:0] l);
        logic [3*GW-1:0] r;
        int c;
        r = '0;
        for (int a = 0; a < 3; a++) begin
            c = int'(g[a*GW +: GW]) + (l[2-a] ? 3 : 0);
            r[a*GW +: GW] = GW'(c % 16);
        end
        return r;
    endfunction

    function automatic logic [3*GW+2:0] to_inj(logic [3*GW-1:0] g, logic [2:0] l);
        logic [3*GW-1:0] r;
        logic [2:0] n;
        int c, v;
        bit hi;
        r = '0;
        n = '0;
        for (int a = 0; a < 3; a++) begin
            c  = int'(g[a*GW +: GW]);
            hi = c >= 3;
            if (l[2-a] && hi)       v = c - 3;
            else if (!l[2-a] || hi) v = c;
            else                    v = c + 3;
            r[a*GW +: GW] = GW'(v % 16);
            n[2-a] = hi;
        end
        return {n, r};
    endfunction

    task automatic model();
        cexp_t c;
        exp_t  e;
        ent_t  h, n;
        int    s, left, sp;
        bit    ready;
        logic [3*GW+2:0] cv;
        c.empty = (ring_life == 0);
        c.ready = fifo.size() < DEPTH;
        qcomb.push_back(c);
        e = '{default: '0};
        if (rst) begin
            fifo.delete();
            merr = 1'b0;
        end else begin
            ready = fifo.size() < DEPTH;
            s = 0;
            e.rsplit = ring_split;
            for (int d = 0; d < NR; d++) begin
                sp = int'(ring_split[d*LW +: LW]);
                if (sp != 0 && !rem_bp[d] && ring_life != 0) begin
                    e.mvalid[d] = 1'b1;
                    e.mlife[d*LW +: LW] = LW'(sp);
                    e.rsplit[d*LW +: LW] = '0;
                    s += sp;
                end
            end
            if (e.mvalid != 0) begin
                e.mpkt  = ring_pkt;
                e.mgcid = to_remote(ring_gcid, lid);
            end
            if (s > int'(ring_life)) merr = 1'b1;
            left = (int'(ring_life) > s) ? int'(ring_life) - s : 0;
            if (left > 0) begin
                e.rpkt  = ring_pkt;
                e.rgcid = ring_gcid;
                e.rnode = ring_node;
                e.rlife = LW'(left);
            end else begin
                e.rsplit = '0;
                if (fifo.size() > 0) begin
                    h = fifo.pop_front();
                    cv = to_inj(h.gcid, lid);
                    e.rpkt  = h.pkt;
                    e.rgcid = cv[3*GW-1:0];
                    e.rnode = cv[3*GW+2:3*GW];
                    e.rlife = h.life;
                end
            end
            if (inj_valid && ready) begin
                n.pkt = inj_pkt; n.gcid = inj_gcid; n.life = inj_life;
                fifo.push_back(n);
            end
        end
        e.cnt = CW'(fifo.size());
        e.err = merr;
        qreg.push_back(e);
    endtask

    initial begin
        cexp_t c;
        exp_t  e;
        forever begin
            @(negedge clk);
            #2;
            if (qcomb.size() > 0) begin
                c = qcomb.pop_front();
                chk("node_empty", 64'(o_empty), 64'(c.empty));
                chk("inj_ready", 64'(inj_ready), 64'(c.ready));
            end
            @(posedge clk);
            #1;
            if (qreg.size() > 0) begin
                e = qreg.pop_front();
                chk("ring_pkt", 64'(o_ring_pkt), 64'(e.rpkt));
                chk("ring_gcid", 64'(o_ring_gcid), 64'(e.rgcid));
                chk("ring_node", 64'(o_ring_node), 64'(e.rnode));
                chk("ring_life", 64'(o_ring_life), 64'(e.rlife));
                chk("ring_split", 64'(o_ring_split), 64'(e.rsplit));
                chk("rem_pkt", 64'(o_rem_pkt), 64'(e.mpkt));
                chk("rem_gcid", 64'(o_rem_gcid), 64'(e.mgcid));
                chk("rem_valid", 64'(o_rem_valid), 64'(e.mvalid));
                chk("rem_life", 64'(o_rem_life), 64'(e.mlife));
                chk("inj_count", 64'(o_cnt), 64'(e.cnt));
                chk("err_underflow", 64'(o_err), 64'(e.err));
            end
        end
    end

    function automatic logic [3*GW-1:0] rnd_gcid();
        return {GW'($urandom_range(0, 5)), GW'($urandom_range(0, 5)),
                GW'($urandom_range(0, 5))};
    endfunction

    task automatic set_ring(int life, int s0, int s1, int bp);
        ring_life  = LW'(life);
        ring_split = {LW'(s1), LW'(s0)};
        rem_bp     = NR'(bp);
        ring_pkt   = $urandom;
        ring_gcid  = rnd_gcid();
        ring_node  = 3'($urandom);
    endtask

    task automatic set_inj(bit v, int life);
        inj_valid = v;
        inj_pkt   = $urandom;
        inj_gcid  = rnd_gcid();
        inj_life  = LW'(life);
    endtask

    task automatic step();
        model();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;
        set_ring(6, 2, 3, 0); set_inj(0, 0); step();
        set_ring(6, 2, 3, 1); step();
        set_ring(4, 2, 0, 0); step();
        set_ring(10, 0, 0, 0); set_inj(1, 7);
        inj_gcid = {4'd4, 4'd1, 4'd5}; step();
        set_ring(5, 2, 3, 0); set_inj(0, 0); step();
        for (int i = 0; i < 6; i++) begin
            set_ring(10, 0, 0, 0); set_inj(1, $urandom_range(1, 31)); step();
        end
        for (int i = 0; i < 5; i++) begin
            set_ring(0, 0, 0, 0); set_inj(0, 0); step();
        end
        set_ring(2, 2, 3, 0); step();
        set_ring(0, 0, 0, 0); step();
        set_ring(9, 1, 1, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_ring(10, 0, 0, 0); set_inj(1, $urandom_range(1, 31)); step();
        end
        rst = 1'b1; step();
        rst = 1'b0; set_inj(0, 0); set_ring(0, 0, 0, 0); step();
        lid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            set_ring(10, 0, 0, 0); set_inj(1, $urandom_range(1, 31)); step();
        end
        for (int i = 0; i < 4; i++) begin
            set_ring(3, 1, 2, 0); set_inj(0, 0); step();
        end
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lid = 3'($urandom);
            rst = ($urandom % 100) == 0;
            set_ring(($urandom % 4 == 0) ? 0 : $urandom_range(1, 31),
                     ($urandom % 3 == 0) ? 0 : $urandom_range(1, 15),
                     ($urandom % 3 == 0) ? 0 : $urandom_range(1, 15),
                     $urandom % 4);
            set_inj(($urandom % 2) == 1, $urandom_range(1, 31));
            step();
        end
        rst = 1'b0;
        set_ring(0, 0, 0, 0); set_inj(0, 0); step();
        @(negedge clk);
        @(negedge clk);
        chk("drain_reg", 64'(qreg.size()), 64'd0);
        chk("drain_comb", 64'(qcomb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
